mul16_seq_ctrl: RTL and testbench



---
 rtl/mul16_seq_ctrl_pkg.sv | 37 +++
 rtl/mul16_seq_ctrl_if.sv | 24 ++
 rtl/mul16_step_mux.sv | 19 +
 rtl/mul16_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_mul16_seq_ctrl.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mul16_seq_ctrl_pkg.sv
// Shared widths, state encoding and step/shift table for the 16x16 sequential multiplier.
package mul16_seq_ctrl_pkg;

    localparam int unsigned HALF_W  = 8;
    localparam int unsigned FULL_W  = 16;
    localparam int unsigned PROD_W  = 32;
    localparam int unsigned STEP_W  = 2;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] ST_MUL  = 2'd1;
    localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

    // Partial-product weights: lo*lo, lo*hi, hi*lo, hi*hi
    localparam logic [SHIFT_W-1:0] SHIFT_LL = 5'd0;
    localparam logic [SHIFT_W-1:0] SHIFT_LH = 5'd8;
    localparam logic [SHIFT_W-1:0] SHIFT_HL = 5'd8;
    localparam logic [SHIFT_W-1:0] SHIFT_HH = 5'd16;

    typedef struct packed {
        logic [FULL_W-1:0] a;
        logic [FULL_W-1:0] b;
    } operands_t;

    function automatic logic [SHIFT_W-1:0] step_shift(input logic [STEP_W-1:0] step);
        logic [SHIFT_W-1:0] sh;
        case (step)
            2'd0:    sh = SHIFT_LL;
            2'd1:    sh = SHIFT_LH;
            2'd2:    sh = SHIFT_HL;
            default: sh = SHIFT_HH;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul16_seq_ctrl_if.sv
// Operand-in / result-out handshake bundle plus the busy status flag.
interface mul16_seq_ctrl_if;
    import mul16_seq_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [FULL_W-1:0] op_a;
    logic [FULL_W-1:0] op_b;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] result;
    logic              busy;

    modport master (
        output in_valid, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_a, op_b, out_ready,
        output in_ready, out_valid, result, busy
    );

endinterface

// File: rtl/mul16_step_mux.sv
// Picks the operand halves and the accumulate shift for the current partial-product step.
module mul16_step_mux
    import mul16_seq_ctrl_pkg::*;
(
    input  logic [STEP_W-1:0]  step_i,
    input  operands_t          ops_i,
    output logic [HALF_W-1:0]  a_c_o,
    output logic [HALF_W-1:0]  b_c_o,
    output logic [SHIFT_W-1:0] shift_c_o
);

    // step[1] selects the high half of a, step[0] the high half of b
    always_comb begin
        a_c_o     = step_i[1] ? ops_i.a[FULL_W-1:HALF_W] : ops_i.a[HALF_W-1:0];
        b_c_o     = step_i[0] ? ops_i.b[FULL_W-1:HALF_W] : ops_i.b[HALF_W-1:0];
        shift_c_o = step_shift(step_i);
    end

endmodule

// File: rtl/mul16_seq_ctrl.sv
// Sequences four 8x8 partial products through an external multiplier into a 32-bit product.
module mul16_seq_ctrl
    import mul16_seq_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 0
)
(
    input  logic               clk,
    input  logic               rst,
    mul16_seq_ctrl_if.slave    bus,
    output logic [HALF_W-1:0]  mul_a,
    output logic [HALF_W-1:0]  mul_b,
    input  logic [FULL_W-1:0]  mul_p
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               cyc_q, cyc_d;
    operands_t          ops_q, ops_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [PROD_W-1:0]  result_q, result_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic [HALF_W-1:0]  sel_a_c;
    logic [HALF_W-1:0]  sel_b_c;
    logic [SHIFT_W-1:0] shift_c;
    logic               step_last_c;

    mul16_step_mux u_step_mux (
        .step_i    (step_q),
        .ops_i     (ops_q),
        .a_c_o     (sel_a_c),
        .b_c_o     (sel_b_c),
        .shift_c_o (shift_c)
    );

    // With a registered multiplier the product is valid on the second cycle of each step
    assign step_last_c = (MUL_LAT == 0) || cyc_q;

    assign mul_a         = (state_q == ST_MUL) ? sel_a_c : '0;
    assign mul_b         = (state_q == ST_MUL) ? sel_b_c : '0;
    assign bus.in_ready  = (state_q == ST_IDLE) & ~rst;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= '0;
            cyc_q       <= 1'b0;
            ops_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cyc_q       <= cyc_d;
            ops_q       <= ops_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        cyc_d       = cyc_q;
        ops_d       = ops_q;
        acc_d       = acc_q;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    ops_d.a  = bus.op_a;
                    ops_d.b  = bus.op_b;
                    acc_d    = '0;
                    step_d   = '0;
                    cyc_d    = 1'b0;
                    result_d = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_MUL;
                end
            end
            ST_MUL: begin
                if (step_last_c) begin
                    acc_d  = acc_q + (PROD_W'(mul_p) << shift_c);
                    cyc_d  = 1'b0;
                    step_d = step_q + 2'd1;
                    if (step_q == 2'd3) begin
                        result_d    = acc_d;
                        out_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end else begin
                    cyc_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mul16_seq_ctrl.sv
// Directed bench: one combinational-multiplier instance and one registered-multiplier instance.
module tb_mul16_seq_ctrl;
    import mul16_seq_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vectors;
    int miscompares;

    mul16_seq_ctrl_if bus0();
    mul16_seq_ctrl_if bus1();

    logic [7:0]  mul_a0, mul_b0, mul_a1, mul_b1;
    logic [15:0] mul_p0, mul_p1;

    // Behavioural 8x8 multipliers: combinational for MUL_LAT=0, registered for MUL_LAT=1
    assign mul_p0 = {8'd0, mul_a0} * {8'd0, mul_b0};
    always @(posedge clk) mul_p1 <= {8'd0, mul_a1} * {8'd0, mul_b1};

    mul16_seq_ctrl #(.MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0)
    );

    mul16_seq_ctrl #(.MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .mul_a(mul_a1), .mul_b(mul_b1), .mul_p(mul_p1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.op_a = '0; bus0.op_b = '0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.op_a = '0; bus1.op_b = '0; bus1.out_ready = 1'b0;

        // Reset held for two edges, then released
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_out_valid", 32'(bus0.out_valid), 32'd0);
        check("rst_result",    bus0.result,         32'd0);
        check("rst_busy",      32'(bus0.busy),      32'd0);
        check("rst_mul_a",     32'(mul_a0),         32'd0);
        check("rst_mul_b",     32'(mul_b0),         32'd0);
        check("rst_in_ready",  32'(bus0.in_ready),  32'd1);
        check("rst1_in_ready", 32'(bus1.in_ready),  32'd1);
        check("rst1_result",   bus1.result,         32'd0);

        // 100 * 23 with a combinational multiplier
        exp_a = '{8'h64, 8'h64, 8'h00, 8'h00};
        exp_b = '{8'h17, 8'h00, 8'h17, 8'h00};
        bus0.op_a = 16'd100; bus0.op_b = 16'd23; bus0.in_valid = 1'b1; bus0.out_ready = 1'b1;
        tick();
        bus0.in_valid = 1'b0; bus0.op_a = 16'hDEAD; bus0.op_b = 16'hBEEF;
        check("a_busy", 32'(bus0.busy), 32'd1);
        for (int s = 0; s < 4; s++) begin
            check($sformatf("a_mul_a_s%0d", s), 32'(mul_a0), 32'(exp_a[s]));
            check($sformatf("a_mul_b_s%0d", s), 32'(mul_b0), 32'(exp_b[s]));
            check($sformatf("a_ov_s%0d", s), 32'(bus0.out_valid), 32'd0);
            tick();
        end
        check("a_out_valid", 32'(bus0.out_valid), 32'd1);
        check("a_result",    bus0.result,         32'd2300);
        check("a_done_mul_a", 32'(mul_a0),        32'd0);
        tick();
        check("a_ov_drop",   32'(bus0.out_valid), 32'd0);
        check("a_busy_drop", 32'(bus0.busy),      32'd0);
        check("a_result_kept", bus0.result,       32'd2300);

        // Maximum operands
        bus0.op_a = 16'hFFFF; bus0.op_b = 16'hFFFF; bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("max_mul_a_s%0d", s), 32'(mul_a0), 32'hFF);
            check($sformatf("max_mul_b_s%0d", s), 32'(mul_b0), 32'hFF);
            tick();
        end
        check("max_out_valid", 32'(bus0.out_valid), 32'd1);
        check("max_result",    bus0.result,         32'hFFFE0001);
        tick();

        // Backpressure with a second request waiting
        bus0.out_ready = 1'b0;
        bus0.op_a = 16'h1234; bus0.op_b = 16'h5678; bus0.in_valid = 1'b1;
        tick();
        bus0.op_a = 16'd7; bus0.op_b = 16'd9;
        for (int s = 0; s < 4; s++) begin
            check($sformatf("bp_in_ready_mul%0d", s), 32'(bus0.in_ready), 32'd0);
            tick();
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp_ov_c%0d", c),       32'(bus0.out_valid), 32'd1);
            check($sformatf("bp_result_c%0d", c),   bus0.result,         32'h06260060);
            check($sformatf("bp_in_ready_c%0d", c), 32'(bus0.in_ready),  32'd0);
            tick();
        end
        bus0.out_ready = 1'b1;
        tick();
        check("bp_ov_drop",     32'(bus0.out_valid), 32'd0);
        check("bp_in_ready_up", 32'(bus0.in_ready),  32'd1);
        tick();
        bus0.in_valid = 1'b0;
        check("bp2_busy",  32'(bus0.busy),     32'd1);
        check("bp2_mul_a", 32'(mul_a0),        32'h07);
        check("bp2_mul_b", 32'(mul_b0),        32'h09);
        tick(); tick(); tick(); tick();
        check("bp2_out_valid", 32'(bus0.out_valid), 32'd1);
        check("bp2_result",    bus0.result,         32'd63);
        tick();

        // Reset during step 2 abandons the operation
        bus0.op_a = 16'hABCD; bus0.op_b = 16'h1357; bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        tick(); tick();
        check("mr_step2_mul_a", 32'(mul_a0), 32'hAB);
        check("mr_step2_mul_b", 32'(mul_b0), 32'h57);
        rst = 1'b1;
        tick();
        check("mr_busy",      32'(bus0.busy),      32'd0);
        check("mr_out_valid", 32'(bus0.out_valid), 32'd0);
        check("mr_mul_a",     32'(mul_a0),         32'd0);
        check("mr_result",    bus0.result,         32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            check($sformatf("mr_no_ov_c%0d", c), 32'(bus0.out_valid), 32'd0);
            tick();
        end
        bus0.op_a = 16'd3; bus0.op_b = 16'd5; bus0.in_valid = 1'b1;
        tick();
        bus0.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        check("mr_next_out_valid", 32'(bus0.out_valid), 32'd1);
        check("mr_next_result",    bus0.result,         32'd15);
        tick();

        // 300 * 700 with a registered multiplier: each pair held two cycles
        exp_a = '{8'h2C, 8'h2C, 8'h01, 8'h01};
        exp_b = '{8'hBC, 8'h02, 8'hBC, 8'h02};
        bus1.out_ready = 1'b1;
        bus1.op_a = 16'd300; bus1.op_b = 16'd700; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        for (int s = 0; s < 4; s++) begin
            for (int h = 0; h < 2; h++) begin
                check($sformatf("l1_mul_a_s%0d_%0d", s, h), 32'(mul_a1), 32'(exp_a[s]));
                check($sformatf("l1_mul_b_s%0d_%0d", s, h), 32'(mul_b1), 32'(exp_b[s]));
                check($sformatf("l1_ov_s%0d_%0d", s, h), 32'(bus1.out_valid), 32'd0);
                tick();
            end
        end
        check("l1_out_valid", 32'(bus1.out_valid), 32'd1);
        check("l1_result",    bus1.result,         32'd210000);
        tick();
        check("l1_ov_drop",   32'(bus1.out_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
